// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   imem_state_t : LOAD (core held, program streaming in) / RUN (serving fetches)
//   IMEM_DEPTH   : default number of 32-bit instruction words
//   IMEM_ADDR_W  : default memory index width, log2(IMEM_DEPTH)
//   IMEM_NOP     : default word returned for out-of-range or held fetches
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam int          IMEM_DEPTH  = 64;
  localparam int          IMEM_ADDR_W = 6;
  localparam logic [31:0] IMEM_NOP    = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage, synchronous write, asynchronous read.
// Ports:
//   clk   in  : rising-edge write clock
//   we    in  : write enable
//   waddr in  : write index
//   wdata in  : word to store
//   raddr in  : read index
//   rdata out : word at raddr, combinational
// The array carries no reset; stale words are hidden by the range check upstream.
module imem_array #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read: the core latches Instr on the same edge that moves PC.
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_server.sv
// imem_server: instruction-memory responder for the mips_vf multicycle core.
// A program is streamed in over a valid/ready load port while the core is held
// in reset; afterwards the word-addressed PC is answered combinationally.
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   load_valid/ready   : load stream handshake, one word per cycle
//   load_data          : instruction word to store
//   load_last          : final program word marker
//   reload             : in RUN, restart loading and re-hold the core
//   PC / Instr         : word-index fetch address / instruction returned
//   core_hold          : high while loading, OR'd into the core reset
//   prog_len           : number of words loaded
//   oob                : PC at or beyond prog_len while in RUN
//   checksum           : additive checksum of loaded words
// Optional feature macro: IMEM_CHECKSUM_EN (undefined: checksum tied to zero).
module imem_server
  import imem_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [31:0]     load_data,
  input  logic            load_last,
  output logic            load_ready,
  input  logic            reload,
  input  logic [31:0]     PC,
  output logic [31:0]     Instr,
  output logic            core_hold,
  output logic [ADDR_W:0] prog_len,
  output logic            oob,
  output logic [31:0]     checksum
);

  localparam logic [ADDR_W:0] ZERO_PTR = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_PTR  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  imem_state_t     state_r;
  logic [ADDR_W:0] wr_ptr_r;
  logic            accept_s;
  logic            in_range_s;
  logic [31:0]     len_ext_s;
  logic [31:0]     rd_data_s;

  // wr_ptr reaches DEPTH only on the edge that also enters RUN, so in LOAD
  // the pointer compare alone decides readiness.
  assign load_ready = (state_r == LOAD) && (wr_ptr_r != FULL_PTR);
  assign accept_s   = load_valid && load_ready;
  assign core_hold  = (state_r == LOAD);
  assign prog_len   = wr_ptr_r;
  assign len_ext_s  = {{(31-ADDR_W){1'b0}}, wr_ptr_r};

  // Load/run sequencing and write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= LOAD;
      wr_ptr_r <= ZERO_PTR;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
            // Leave LOAD on the marked last word or when the array fills.
            if (load_last || (wr_ptr_r == LAST_PTR)) begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          if (reload) begin
            state_r  <= LOAD;
            wr_ptr_r <= ZERO_PTR;
          end
        end
        default: begin
          state_r  <= LOAD;
          wr_ptr_r <= ZERO_PTR;
        end
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running modulo-2^32 sum of accepted words, cleared with the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_r <= 32'h0000_0000;
    end else if ((state_r == RUN) && reload) begin
      checksum_r <= 32'h0000_0000;
    end else if (accept_s) begin
      checksum_r <= checksum_r + load_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 32'h0000_0000;
`endif

  // Fetch range check uses the full 32-bit PC so aliased high addresses miss.
  always_comb begin
    in_range_s = 1'b0;
    Instr      = NOP_WORD;
    oob        = 1'b0;
    if (state_r == RUN) begin
      in_range_s = (PC < len_ext_s);
      oob        = !in_range_s;
      if (in_range_s) begin
        Instr = rd_data_s;
      end else begin
        Instr = NOP_WORD;
      end
    end else begin
      in_range_s = 1'b0;
      Instr      = NOP_WORD;
      oob        = 1'b0;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (accept_s && !reset),
    .waddr(wr_ptr_r[ADDR_W-1:0]),
    .wdata(load_data),
    .raddr(PC[ADDR_W-1:0]),
    .rdata(rd_data_s)
  );

endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: randomized scoreboard bench for imem_server.
// The driver keeps a word-level model of the loaded program; each observation
// pushes the predicted outputs, and a negedge monitor pops and compares them.
module tb_imem_server;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        reload = 1'b0;
  logic [31:0] PC = 32'h0;
  logic [31:0] Instr;
  logic        core_hold;
  logic [6:0]  prog_len;
  logic        oob;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  imem_server dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .reload    (reload),
    .PC        (PC),
    .Instr     (Instr),
    .core_hold (core_hold),
    .prog_len  (prog_len),
    .oob       (oob),
    .checksum  (checksum)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        hold;
    logic        ready;
    logic [31:0] len;
    logic [31:0] instr;
    logic        oob;
    logic [31:0] sum;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic obs_req = 1'b0;

  // Reference model: the program as a plain array plus length and mode.
  logic [31:0] m_mem [DEPTH];
  int          m_len = 0;
  bit          m_run = 1'b0;
  logic [31:0] m_sum = 32'h0;

  task automatic chk(input string name, input logic [31:0] pc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pc=%h actual=%h required=%h", name, pc, act, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    bit   inr;
    inr     = m_run && (pc < 32'(m_len));
    e.pc    = pc;
    e.hold  = !m_run;
    e.ready = !m_run && (m_len < DEPTH);
    e.len   = 32'(m_len);
    e.instr = inr ? m_mem[pc % 32'(DEPTH)] : 32'h0;
    e.oob   = m_run && !(pc < 32'(m_len));
`ifdef IMEM_CHECKSUM_EN
    e.sum   = m_sum;
`else
    e.sum   = 32'h0;
`endif
    return e;
  endfunction

  // Apply the effect of the currently driven inputs at the coming edge.
  task automatic model_edge();
    if (reset) begin
      m_run = 1'b0;
      m_len = 0;
      m_sum = 32'h0;
    end else if (!m_run) begin
      if (load_valid && (m_len < DEPTH)) begin
        m_mem[m_len] = load_data;
        m_len++;
        m_sum += load_data;
        if (load_last || (m_len == DEPTH)) m_run = 1'b1;
      end
    end else if (reload) begin
      m_run = 1'b0;
      m_len = 0;
      m_sum = 32'h0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    obs_req = 1'b0;
  endtask

  task automatic observe(input logic [31:0] pc);
    load_valid = 1'b0;
    load_last  = 1'b0;
    reload     = 1'b0;
    reset      = 1'b0;
    PC         = pc;
    sb.push_back(predict(pc));
    obs_req    = 1'b1;
    step();
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    reset      = 1'b0;
    reload     = 1'b0;
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 70));
  endfunction

  // Monitor: compare every requested observation against its prediction.
  always @(negedge clk) begin
    if (obs_req) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("core_hold",  e.pc, 32'(core_hold),  32'(e.hold));
        chk("load_ready", e.pc, 32'(load_ready), 32'(e.ready));
        chk("prog_len",   e.pc, 32'(prog_len),   e.len);
        chk("instr",      e.pc, Instr,           e.instr);
        chk("oob",        e.pc, 32'(oob),        32'(e.oob));
        chk("checksum",   e.pc, checksum,        e.sum);
      end
    end
  end

  initial begin
    // Reset held for two edges, then LOAD state with NOP fetches.
    reset = 1'b1;
    step();
    step();
    observe(32'h0);
    observe(32'h5);
    observe(32'hFFFF_FFFF);

    // Short program.
    load_word(32'h2008_0005, 1'b0);
    load_word(32'h2009_0003, 1'b0);
    load_word(32'h0109_5020, 1'b1);
    observe(32'h2);
    observe(32'h3);
    observe(32'h0);
    observe(32'h1);
    observe(32'hFFFF_FFFF);
    observe(32'd65);

    // Reload from RUN.
    pulse_reload();
    observe(32'h0);

    // Fill to capacity without a last marker, then an extra word.
    for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
    observe(32'd63);
    load_word(32'hDEAD_BEEF, 1'b0);
    observe(32'd63);
    observe(32'd64);
    observe(32'd0);

    // Gapped load of four words.
    pulse_reload();
    for (int i = 0; i < 4; i++) begin
      step();
      load_word($urandom, (i == 3) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 5; i++) observe(32'(i));

    // Reset mid-load, then reset and reload together.
    pulse_reload();
    load_word($urandom, 1'b0);
    load_word($urandom, 1'b0);
    reset = 1'b1;
    step();
    observe(32'h0);
    load_word(32'h1234_5678, 1'b1);
    observe(32'h0);
    reset  = 1'b1;
    reload = 1'b1;
    step();
    observe(32'h0);

    // Checksum wrap-around.
    load_word(32'hFFFF_FFFF, 1'b0);
    load_word(32'h0000_0002, 1'b1);
    observe(32'h0);
    observe(32'h1);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        pulse_reload();
      end
      for (int c = 0; c < 200 && !m_run; c++) begin
        case ($urandom_range(0, 39))
          0: begin
            reset = 1'b1;
            step();
            reset = 1'b0;
          end
          1, 2, 3: step();
          4, 5:    observe(rand_pc());
          6: begin
            reload = 1'b1;
            step();
            reload = 1'b0;
          end
          default: load_word($urandom, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        endcase
      end
      for (int k = 0; k < 4; k++) observe(rand_pc());
      observe(32'(m_len));
      if (m_len > 0) observe(32'(m_len - 1));
    end

    step();
    step();
    chk("sb_drain", 32'h0, 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder for the `mips_vf` multicycle core, which leaves instruction memory external and samples `Instr` when it latches its instruction register. `imem_server` accepts a program from the bench or host over a valid/ready load stream and holds the core in reset until loading completes. It then answers the core's word-addressed `PC` with the stored instruction combinationally. It sits beside `mips_vf` in the top level, driving `Instr` and `core_hold`.

## Interface
- `DEPTH`, 64: number of 32-bit instruction words; must be a power of two.
- `ADDR_W`, 6: equals log2(`DEPTH`); width of the memory index.
- `NOP_WORD`, 32'h0000_0000: instruction returned for out-of-range fetches.

Ports:
- `clk`  in  1: rising-edge clock, shared with the core.
- `reset`  in  1: synchronous, active-high; clears all state at a rising `clk`.
- `load_valid`  in  1: load word present.
- `load_data`  in  32: instruction word to store.
- `load_last`  in  1: qualifies `load_data` as the final program word.
- `load_ready`  out  1: block can accept a load word.
- `reload`  in  1: in RUN, restart loading and re-hold the core.
- `PC`  in  32: core program counter, interpreted as a word index.
- `Instr`  out  32: instruction at `PC`.
- `core_hold`  out  1: OR into the core reset; high while loading.
- `prog_len`  out  ADDR_W+1: number of words loaded.
- `oob`  out  1: `PC` is at or beyond `prog_len` while in RUN.
- `checksum`  out  32: additive checksum of the loaded words (see Configuration).

## Operation
- FSM has two states: LOAD and RUN. `reset` forces LOAD.
- **LOAD state**
  - `load_ready` = (`wr_ptr` != `DEPTH`). `wr_ptr` is ADDR_W+1 bits wide.
  - A word is accepted when `load_valid` and `load_ready` are both high at a rising edge. On accept: `mem[wr_ptr[ADDR_W-1:0]]` <= `load_data`, and `wr_ptr` increments.
  - The FSM moves LOAD -> RUN on the edge that accepts a word with `load_last` high.
  - The FSM also moves LOAD -> RUN on the edge where `wr_ptr` reaches `DEPTH`, with or without `load_last`.
- **RUN state**
  - `load_ready` = 0; load inputs are ignored.
  - `reload` high at an edge: clear `wr_ptr` and `checksum`, go to LOAD. Memory contents are not cleared.
- **Outputs**
  - `core_hold` = 1 exactly when state is LOAD.
  - `prog_len` = `wr_ptr`.
- **Fetch path (combinational)**
  - Index = `PC[ADDR_W-1:0]`. A fetch is in range iff `PC` < `prog_len`, using the full 32-bit compare.
  - In range: `Instr` = `mem[index]`. Out of range, or in LOAD: `Instr` = `NOP_WORD`.
  - `oob` = (state == RUN) && !(`PC` < `prog_len`).
- **Boundaries**
  - `load_valid` with `load_data` when `prog_len` = `DEPTH`: no accept, because `load_ready` is low.
  - `reload` and `reset` asserted together: `reset` wins. The result is identical (LOAD, cleared state).
  - `reset` mid-load: `wr_ptr` returns to 0. Words already written stay in the array but are unreachable until rewritten.
  - A zero-length program cannot occur: at least one word, the `load_last` word, is always accepted before RUN.

## Timing
- Reset values:
  - state = LOAD, `core_hold` = 1, `load_ready` = 1.
  - `prog_len` = 0, `checksum` = 0, `oob` = 0.
  - `Instr` = `NOP_WORD`.
- Load throughput: one word per cycle.
- Release latency: `core_hold` falls in the cycle after the edge that accepts the last word. The core's first fetch (PC = 0) occurs on the following edge.
- `Instr` has zero cycles of latency from `PC`. This is required because the core updates `PC` and latches `Instr` on the same edge.
- Memory is write-only during LOAD. In RUN there are no read/write hazards.

## Configuration
- Macro: `IMEM_CHECKSUM_EN`.
- **Defined:** on every accepted word, `checksum` <= `checksum` + `load_data`, modulo 2^32. `checksum` clears on `reset` and on `reload`.
- **Undefined:** `checksum` is tied to 0 and no adder is synthesized. All other behaviour is unchanged.

## Structure
- Package `imem_pkg` holds:
  - the `imem_state_t` enum (LOAD, RUN);
  - `IMEM_DEPTH` and `IMEM_ADDR_W` defaults;
  - `IMEM_NOP` = 32'h0.
- One sub-module: `imem_array`, a DEPTH x 32 storage array with synchronous write and asynchronous read.
- The FSM, pointer, checksum and range check live in `imem_server`.

## Test plan
- **Reset state:** `reset` high for 2 cycles -> `core_hold` = 1, `load_ready` = 1, `prog_len` = 0, `Instr` = 0 for any `PC`.
- **Short program:** load 3 words 32'h20080005, 32'h20090003, 32'h01095020, with `load_last` on the third ->
  - `core_hold` = 0 one cycle later;
  - `prog_len` = 3;
  - `PC` = 2 gives `Instr` = 32'h01095020;
  - `PC` = 3 gives `Instr` = 0 and `oob` = 1.
- **Fill to capacity:** 64 words with no `load_last` -> RUN after the 64th accept; `load_ready` = 0; a 65th `load_valid` is not accepted; `prog_len` = 64.
- **Backpressure and gaps:** `load_valid` toggled every other cycle for 4 words -> exactly 4 accepts, stored in order at indices 0..3.
- **Reload and reset mid-load:**
  - In RUN, pulse `reload` -> `core_hold` = 1, `prog_len` = 0.
  - Load 2 words, then assert `reset` -> `prog_len` = 0 and state is LOAD.
- **Checksum (`IMEM_CHECKSUM_EN` defined):** load 32'hFFFFFFFF, then 32'h00000002 with `load_last` -> `checksum` = 32'h00000001 (wrap-around). With the macro undefined -> `checksum` = 0.
